// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM encoding, RGB565 pixel width, counter widths and default frame/window geometry for the camera window writer
package cam_pkg;
  typedef enum logic [1:0] {
    ST_SYNC    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_HOLD    = 2'b10,
    ST_BAD     = 2'b11
  } cam_state_e;
  localparam int RGB565_W    = 16;
  localparam int FRAME_W_DEF = 640;
  localparam int FRAME_H_DEF = 480;
  localparam int WIN_W_DEF   = 256;
  localparam int WIN_H_DEF   = 256;
  localparam int HC_W        = 10;
  localparam int VC_W        = 9;
endpackage

// File: rtl/cam_pos_counter.sv
// cam_pos_counter: sensor column/line position (clk, rst_n, pix_valid_i, frame_done_i in; hc_o, vc_o out), cleared by frame_done_i
module cam_pos_counter
  import cam_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_valid_i,
  input  logic            frame_done_i,
  output logic [HC_W-1:0] hc_o,
  output logic [VC_W-1:0] vc_o
);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(FRAME_W - 1);
  localparam logic [VC_W-1:0] VC_LAST = VC_W'(FRAME_H - 1);
  logic [HC_W-1:0] hc_q, hc_d;
  logic [VC_W-1:0] vc_q, vc_d;
  logic            hc_end;
  always_comb begin
    hc_end = hc_q == HC_LAST;
    hc_d   = frame_done_i ? '0 : !pix_valid_i ? hc_q : hc_end ? '0 : hc_q + 1'b1;
    vc_d   = frame_done_i ? '0 : !(pix_valid_i && hc_end) ? vc_q : (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end
  assign hc_o = hc_q;
  assign vc_o = vc_q;
endmodule

// File: rtl/cam_window_writer.sv
// cam_window_writer: crops/decimates a camera pixel stream into a ping-pong window buffer (pixel/frame strobes, write, decim, win_x/win_y in; wr_en/wr_addr/wr_data, rd_bank, frame_ready/frame_err, state_o out)
module cam_window_writer
  import cam_pkg::*;
#(
  parameter int PIX_W      = RGB565_W,
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int FRAME_H    = FRAME_H_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int WIN_H      = WIN_H_DEF,
  parameter int DOUBLE_BUF = 1,
  localparam int CW = $clog2(WIN_W),
  localparam int RW = $clog2(WIN_H),
  localparam int AW = CW + RW + DOUBLE_BUF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             frame_done,
  input  logic             write,
  input  logic             decim,
  input  logic [HC_W-1:0]  win_x,
  input  logic [VC_W-1:0]  win_y,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             rd_bank,
  output logic             frame_ready,
  output logic             frame_err,
  output logic [1:0]       state_o
);
  localparam int NPIX  = WIN_W * WIN_H;
  localparam int CNT_W = $clog2(NPIX) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NPIX);
  localparam logic [HC_W:0]    SPAN_X   = (HC_W + 1)'(WIN_W);
  localparam logic [VC_W:0]    SPAN_Y   = (VC_W + 1)'(WIN_H);
  cam_state_e        state_q, state_d;
  logic [HC_W-1:0]   hc, win_x_q, win_x_d;
  logic [VC_W-1:0]   vc, win_y_q, win_y_d;
  logic              decim_q, decim_d;
  logic [HC_W:0]     dx, span_x;
  logic [VC_W:0]     dy, span_y;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW+RW:0]    addr_full;
  logic              in_win, take;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic              ready_d, err_d, ready_q, err_q;
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  cam_pos_counter #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) u_pos (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_valid_i  (pix_valid),
    .frame_done_i (frame_done),
    .hc_o         (hc),
    .vc_o         (vc)
  );
  always_comb begin
    dx        = {1'b0, hc} - {1'b0, win_x_q};
    dy        = {1'b0, vc} - {1'b0, win_y_q};
    span_x    = decim_q ? SPAN_X << 1 : SPAN_X;
    span_y    = decim_q ? SPAN_Y << 1 : SPAN_Y;
    in_win    = (dx < span_x) && (dy < span_y) && (!decim_q || (!dx[0] && !dy[0]));
    col       = decim_q ? dx[CW:1] : dx[CW-1:0];
    row       = decim_q ? dy[RW:1] : dy[RW-1:0];
    addr_full = {wr_bank_q, row, col};
    take      = (state_q == ST_CAPTURE) && pix_valid && !frame_done && in_win;
    state_d   = (state_q == ST_BAD) ? ST_SYNC : frame_done ? (write ? ST_CAPTURE : ST_HOLD) : state_q;
    ready_d   = frame_done && (state_q == ST_CAPTURE) && (cnt_q == CNT_FULL);
    err_d     = frame_done && (state_q == ST_CAPTURE) && (cnt_q != CNT_FULL);
    rd_bank_d = ready_d ? wr_bank_q : rd_bank_q;
    wr_bank_d = (ready_d && DOUBLE_BUF != 0) ? !wr_bank_q : wr_bank_q;
    cnt_d     = frame_done ? '0 : (take && cnt_q != CNT_FULL) ? cnt_q + 1'b1 : cnt_q;
    win_x_d   = frame_done ? win_x : win_x_q;
    win_y_d   = frame_done ? win_y : win_y_q;
    decim_d   = frame_done ? decim : decim_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SYNC;
      cnt_q     <= '0;
      wr_bank_q <= 1'b1;
      rd_bank_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      win_x_q   <= '0;
      win_y_q   <= '0;
      decim_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      wr_en_q   <= take;
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
      decim_q   <= decim_d;
      if (take) begin
        wr_addr_q <= addr_full[AW-1:0];
        wr_data_q <= pix_data;
      end
    end
  end
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_bank     = (DOUBLE_BUF != 0) && rd_bank_q;
  assign frame_ready = ready_q;
  assign frame_err   = err_q;
  assign state_o     = state_q;
endmodule
